// File: rtl/mem_bus_if.sv
// Multicycle memory bus adapter: it registers a controller access, runs it on the external bus and stalls the controller until the access completes.
// Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles without mem_ready and raise a sticky err.
module mem_bus_if #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic        irwrite,
   output logic        stall,
   output logic [31:0] instr,
   output logic [31:0] mdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t state;
   logic   lat_irwrite;
   logic   start;
   logic   unused_bits;

   assign start = (state == IDLE) && (rd_req || wr_req);

   // The stall goes high in the same cycle as the request so the controller holds its state.
   assign stall = start || (state == BUSY);

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] busy_cnt;
   logic          timed_out;

   assign timed_out   = (busy_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign unused_bits = ^addr[1:0];
`else
   assign err         = 1'b0;
   assign unused_bits = ^{addr[1:0], 32'(TIMEOUT_CYCLES)};
`endif

   // Only word addresses reach the bus. A simultaneous write wins and never loads instr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         lat_irwrite <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         instr       <= '0;
         mdata       <= '0;
`ifdef MEM_TIMEOUT_EN
         busy_cnt    <= '0;
         err         <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mem_addr    <= addr[31:2];
                  mem_wdata   <= wdata;
                  mem_we      <= wr_req;
                  lat_irwrite <= irwrite & ~wr_req;
                  mem_req     <= 1'b1;
                  state       <= BUSY;
`ifdef MEM_TIMEOUT_EN
                  busy_cnt    <= '0;
`endif
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  if (!mem_we) begin
                     if (lat_irwrite) begin
                        instr <= mem_rdata;
                     end else begin
                        mdata <= mem_rdata;
                     end
                  end
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (timed_out) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  err     <= 1'b1;
                  state   <= DONE;
               end else begin
                  busy_cnt <= busy_cnt + CW'(1);
               end
`endif
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_if.sv
// Scoreboard bench for mem_bus_if: expected bus transactions are queued at request time and checked when the DUT raises mem_req.
// Build with MEM_TIMEOUT_EN defined to also exercise the timeout path (TIMEOUT_CYCLES=4).
module tb_mem_bus_if;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rd_req;
   logic        wr_req;
   logic        irwrite;
   logic        stall;
   logic [31:0] instr;
   logic [31:0] mdata;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        err;

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        sbQueue[$];
   int          testsRun;
   int          testsFailed;
   logic [31:0] expInstr;
   logic [31:0] expMdata;
   logic        expErr;

   mem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .rd_req    (rd_req),
      .wr_req    (wr_req),
      .irwrite   (irwrite),
      .stall     (stall),
      .instr     (instr),
      .mdata     (mdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Runs one access, playing the memory with mem_ready on BUSY cycle readyAt (0 = first).
   task automatic applyStimulus(input logic rd, input logic wr, input logic irw,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdat, input int readyAt,
                                input bit holdInDone);
      exp_t e;
      exp_t cur;
      int   stalls;
      e.we    = wr;
      e.addr  = a[31:2];
      e.wdata = wd;
      cur     = e;
      stalls  = 0;
      @(negedge clk);
      rd_req  = rd;
      wr_req  = wr;
      irwrite = irw;
      addr    = a;
      wdata   = wd;
      sbQueue.push_back(e);
      #1;
      if (stall) stalls++;
      @(negedge clk);
      rd_req  = 1'b0;
      wr_req  = 1'b0;
      irwrite = 1'b0;
      addr    = $urandom;
      wdata   = $urandom;
      for (int c = 0; c < 64; c++) begin
         if (c == 0) begin
            if (sbQueue.size() == 0) begin
               checkOutput("sbEmpty", 32'd1, 32'd0);
            end else begin
               cur = sbQueue.pop_front();
            end
         end
         checkOutput("busyReq", {31'd0, mem_req}, 32'd1);
         checkOutput("busyWe", {31'd0, mem_we}, {31'd0, cur.we});
         checkOutput("busyAddr", {2'd0, mem_addr}, {2'd0, cur.addr});
         checkOutput("busyWdata", mem_wdata, cur.wdata);
         mem_ready = (c == readyAt);
         mem_rdata = (c == readyAt) ? rdat : $urandom;
         #1;
         if (stall) stalls++;
         @(negedge clk);
         mem_ready = 1'b0;
         mem_rdata = $urandom;
         if (c == readyAt) break;
      end
      if (!wr) begin
         if (irw) expInstr = rdat;
         else     expMdata = rdat;
      end
      checkOutput("doneStall", {31'd0, stall}, 32'd0);
      checkOutput("doneReq", {31'd0, mem_req}, 32'd0);
      checkOutput("instr", instr, expInstr);
      checkOutput("mdata", mdata, expMdata);
      checkOutput("err", {31'd0, err}, {31'd0, expErr});
      checkOutput("stallCycles", stalls, readyAt + 2);
      if (holdInDone) begin
         rd_req  = 1'b1;
         irwrite = 1'b1;
      end
      @(negedge clk);
      if (holdInDone) begin
         checkOutput("doneIgnored", {31'd0, mem_req}, 32'd0);
         rd_req  = 1'b0;
         irwrite = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      expInstr    = '0;
      expMdata    = '0;
      expErr      = 1'b0;
      reset       = 1'b1;
      addr        = '0;
      wdata       = '0;
      rd_req      = 1'b0;
      wr_req      = 1'b0;
      irwrite     = 1'b0;
      mem_rdata   = '0;
      mem_ready   = 1'b0;

      // Reset state.
      @(negedge clk);
      checkOutput("rstReq", {31'd0, mem_req}, 32'd0);
      checkOutput("rstWe", {31'd0, mem_we}, 32'd0);
      checkOutput("rstAddr", {2'd0, mem_addr}, 32'd0);
      checkOutput("rstWdata", mem_wdata, 32'd0);
      checkOutput("rstInstr", instr, 32'd0);
      checkOutput("rstMdata", mdata, 32'd0);
      checkOutput("rstErr", {31'd0, err}, 32'd0);
      checkOutput("rstStall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // mem_ready outside BUSY does nothing.
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      mem_ready = 1'b0;
      checkOutput("idleReadyReq", {31'd0, mem_req}, 32'd0);
      checkOutput("idleReadyInstr", instr, 32'd0);
      checkOutput("idleReadyMdata", mdata, 32'd0);

      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0, 32'h2010_0005, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_004C, 32'hDEAD_BEEF, 32'h1111_1111, 2, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0103, 32'h0, 32'h1234_5678, 1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h0000_0055, 0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         logic wr;
         logic rd;
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         applyStimulus(rd, wr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of BUSY clears everything at once.
      @(negedge clk);
      rd_req  = 1'b1;
      irwrite = 1'b1;
      addr    = 32'h0000_0040;
      @(negedge clk);
      rd_req  = 1'b0;
      irwrite = 1'b0;
      checkOutput("preRstReq", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midRstReq", {31'd0, mem_req}, 32'd0);
      checkOutput("midRstInstr", instr, 32'd0);
      checkOutput("midRstMdata", mdata, 32'd0);
      checkOutput("midRstAddr", {2'd0, mem_addr}, 32'd0);
      checkOutput("midRstStall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      expInstr = '0;
      expMdata = '0;
      expErr   = 1'b0;

      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h8C08_0004, 1, 1'b0);

`ifdef MEM_TIMEOUT_EN
      begin
         int reqCycles;
         @(negedge clk);
         rd_req = 1'b1;
         addr   = 32'h0000_0020;
         @(negedge clk);
         rd_req    = 1'b0;
         reqCycles = 0;
         for (int c = 0; c < 20; c++) begin
            if (!mem_req) break;
            reqCycles++;
            @(negedge clk);
         end
         checkOutput("toReqCycles", reqCycles, 32'd4);
         checkOutput("toErr", {31'd0, err}, 32'd1);
         checkOutput("toStall", {31'd0, stall}, 32'd0);
         checkOutput("toMdata", mdata, expMdata);
         checkOutput("toInstr", instr, expInstr);
         expErr = 1'b1;
         repeat (3) @(negedge clk);
         checkOutput("toErrSticky", {31'd0, err}, 32'd1);
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
         reset = 1'b1;
         @(negedge clk);
         reset  = 1'b0;
         expErr = 1'b0;
         checkOutput("toErrCleared", {31'd0, err}, 32'd0);
      end
`endif

      checkOutput("finalErr", {31'd0, err}, {31'd0, expErr});
      checkOutput("sbDrained", sbQueue.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mem_bus_if.md
MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum number of BUSY cycles allowed per transaction (used only under MEM_TIMEOUT_EN).
REQ-002 The block SHALL have input clk, 1 bit, the system clock, rising-edge active.
REQ-003 The block SHALL have input reset, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have input addr, 32 bits, the byte address selected by the datapath via iord.
REQ-005 The block SHALL have input wdata, 32 bits, the store data.
REQ-006 The block SHALL have input rd_req, 1 bit, the controller read strobe (FETCH or MEMRD).
REQ-007 The block SHALL have input wr_req, 1 bit, the controller memwrite strobe.
REQ-008 The block SHALL have input irwrite, 1 bit, which routes read data to instr.
REQ-009 The block SHALL have output stall, 1 bit, which freezes controller state advance while high.
REQ-010 The block SHALL have output instr, 32 bits, the instruction register.
REQ-011 The block SHALL have output mdata, 32 bits, the memory data register.
REQ-012 The block SHALL have output mem_req, 1 bit, the external bus request.
REQ-013 The block SHALL have output mem_we, 1 bit, the external write enable.
REQ-014 The block SHALL have output mem_addr, 30 bits, the external word address.
REQ-015 The block SHALL have output mem_wdata, 32 bits, the external write data.
REQ-016 The block SHALL have input mem_rdata, 32 bits, the external read data.
REQ-017 The block SHALL have input mem_ready, 1 bit, the external completion signal.
REQ-018 The block SHALL have output err, 1 bit, the sticky bus timeout flag.

Function
REQ-019 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-020 In IDLE, when rd_req or wr_req is high, the block SHALL latch addr[31:2], wdata, we=wr_req and irwrite, then go to BUSY; addr[1:0] SHALL be ignored.
REQ-021 When rd_req and wr_req are high together, the write SHALL take priority and irwrite SHALL be treated as 0.
REQ-022 stall SHALL be combinational: high when (IDLE and (rd_req or wr_req)) or BUSY; low otherwise.
REQ-023 mem_req SHALL be registered and high only in BUSY; mem_addr, mem_we and mem_wdata SHALL stay stable for the whole of BUSY.
REQ-024 In BUSY, when mem_ready=1 on a read, mem_rdata SHALL be captured into instr if latched irwrite=1, otherwise into mdata; the FSM SHALL then go to DONE.
REQ-025 On a write, mem_ready=1 SHALL move the FSM to DONE with instr and mdata unchanged.
REQ-026 DONE SHALL last exactly one cycle with stall=0, so the controller advances; requests present in DONE SHALL be ignored; the FSM SHALL then return to IDLE.
REQ-027 Minimum latency SHALL be: request in cycle N, mem_req high in N+1, mem_ready in N+1, stall low in N+2 (3-cycle memory state).
REQ-028 mem_ready SHALL be ignored outside BUSY.
REQ-029 instr and mdata SHALL change only on a read completion.

Reset
REQ-030 Asserting reset SHALL immediately set state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr=0, mdata=0, err=0 and any timeout counter to 0, including mid-transaction.
REQ-031 After reset is released, the first request SHALL start a fresh transaction.

Configuration
REQ-032 When macro MEM_TIMEOUT_EN is defined, a counter SHALL count BUSY cycles; if TIMEOUT_CYCLES BUSY cycles elapse without mem_ready, the FSM SHALL drop mem_req, set err (sticky until reset) and go to DONE with instr and mdata unchanged.
REQ-033 When MEM_TIMEOUT_EN is undefined, BUSY SHALL wait indefinitely, err SHALL be tied 0 and no counter SHALL exist.

Verification
REQ-034 Fetch: rd_req=1, irwrite=1, addr=0x00000008, mem_ready=1 in the first BUSY cycle with mem_rdata=0x20100005 -> mem_addr=0x2, stall high 2 cycles, instr=0x20100005, mdata unchanged.
REQ-035 Store: wr_req=1, addr=0x0000004C, wdata=0xDEADBEEF, mem_ready after 3 BUSY cycles -> mem_we=1, mem_addr=0x13, mem_wdata=0xDEADBEEF held 3 cycles, stall high 4 cycles.
REQ-036 Simultaneous rd_req=1, wr_req=1, irwrite=1 -> write issued, instr unchanged.
REQ-037 Reset asserted during BUSY -> mem_req=0 in the same cycle, instr=0, state IDLE.
REQ-038 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req drops after 4 BUSY cycles, err=1 and stays 1 until reset, stall low in DONE.
